// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic units.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic RESULT_RST = 1'b0;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one full-subtractor cell plus a registered borrow.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_brw;
  logic [WIDTH-2:0] r_res;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_shift;

  full_subtractor u_cell (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .bin  (r_brw),
    .d    (w_d),
    .bout (w_bout)
  );

  // New bit enters at the MSB; after WIDTH shifts the word is LSB-aligned.
  assign w_shift = {w_d, r_res};

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      ovf     <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (r_state == SHIFT && r_cnt == CNT_W'(WIDTH - 1)) begin
      ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_brw   <= 1'b0;
      r_res   <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= {WIDTH{RESULT_RST}};
      bout    <= RESULT_RST;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_brw   <= bin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_brw <= w_bout;
          r_res <= w_shift[WIDTH-1:1];
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            diff    <= w_shift;
            bout    <= w_bout;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, corner sequences, random sweep.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf_v;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf_v)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf_v = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbin;
    logic [W-1:0] ediff;
    logic         ebout;
    logic         eovf;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] md, output logic mbo, output logic mov);
    int ua, ub, sa, sb, sr;
    ua  = int'(ma);
    ub  = int'(mb);
    md  = W'(ua - ub - int'(mbin));
    mbo = (ua < ub + int'(mbin));
    sa  = (ua >= 128) ? ua - 256 : ua;
    sb  = (ub >= 128) ? ub - 256 : ub;
    sr  = sa - sb - int'(mbin);
    mov = (sr < -128) || (sr > 127);
  endtask

  // Issue one operation and wait for done; lat is the cycle index at which done was seen.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input bit scramble, output int lat);
    int guard;
    guard = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
    end
    start = 1'b1;
    a     = ta;
    b     = tb_;
    bin   = tbin;
    tick();
    start = 1'b0;
    if (scramble) begin
      a   = W'($urandom);
      b   = W'($urandom);
      bin = 1'($urandom);
    end
    lat = 1;
    while (!done && lat < W + 6) begin
      tick();
      lat++;
    end
    if (!done) check("done_timeout", 32'(lat), 32'(W + 1));
  endtask

  initial begin
    int           lat;
    int           c;
    int           first_done;
    logic [W-1:0] md;
    logic         mbo;
    logic         mov;
    bit           saw_done;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf_v), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // First vector with a cycle-by-cycle busy/done trace.
    start = 1'b1;
    a = vecs[0].va; b = vecs[0].vb; bin = vecs[0].vbin;
    tick();
    start = 1'b0;
    first_done = 0;
    for (c = 1; c <= W + 2; c++) begin
      if (done && first_done == 0) first_done = c;
      if (c <= W + 1) check($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
      else            check($sformatf("busy_c%0d", c), 32'(busy), 32'd0);
      if (c == W + 1) begin
        check("v0_diff", 32'(diff), 32'(vecs[0].ediff));
        check("v0_bout", 32'(bout), 32'(vecs[0].ebout));
      end
      tick();
    end
    check("v0_latency", 32'(first_done), 32'(W + 1));

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, 1'b1, lat);
      $display("vec %0d: a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d ovf=%0d lat=%0d",
               i, vecs[i].va, vecs[i].vb, vecs[i].vbin, diff, bout, ovf_v, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(W + 1));
      check($sformatf("vec%0d_diff", i), 32'(diff), 32'(vecs[i].ediff));
      check($sformatf("vec%0d_bout", i), 32'(bout), 32'(vecs[i].ebout));
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("vec%0d_ovf", i), 32'(ovf_v), 32'(vecs[i].eovf));
`endif
      tick();
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_hold", i), 32'(diff), 32'(vecs[i].ediff));
    end

    // start during SHIFT (cycle 3) and DONE (cycle 9) must be ignored.
    tick();
    start = 1'b1; a = 8'h33; b = 8'h11; bin = 1'b0;
    tick();
    start = 1'b0;
    for (c = 1; c <= W + 3; c++) begin
      start = (c == 3 || c == W + 1);
      a = 8'hF0; b = 8'h0F; bin = 1'b1;
      if (c == W + 1) begin
        check("ign_done", 32'(done), 32'd1);
        check("ign_diff", 32'(diff), 32'h22);
      end
      tick();
    end
    start = 1'b0;
    check("ign_idle", 32'(busy), 32'd0);
    check("ign_hold", 32'(diff), 32'h22);
    $display("ignore-start: diff=%02h busy=%0d", diff, busy);

    // start held high: done pulses spaced WIDTH+2 cycles apart.
    start = 1'b1; a = 8'h44; b = 8'h04; bin = 1'b0;
    c = 0;
    while (!done && c < 30) begin tick(); c++; end
    check("b2b_first", 32'(done), 32'd1);
    tick();
    c = 1;
    while (!done && c < 30) begin tick(); c++; end
    start = 1'b0;
    check("b2b_spacing", 32'(c), 32'(W + 2));
    check("b2b_diff", 32'(diff), 32'h40);
    $display("back-to-back: spacing=%0d diff=%02h", c, diff);
    tick();

    // Asynchronous reset in the middle of an operation.
    tick();
    start = 1'b1; a = 8'h99; b = 8'h11; bin = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("arst_no_done", 32'(saw_done), 32'd0);
    run_op(8'h99, 8'h11, 1'b0, 1'b0, lat);
    check("arst_fresh_diff", 32'(diff), 32'h88);
    check("arst_fresh_bout", 32'(bout), 32'd0);
    $display("reset-abort: fresh diff=%02h bout=%0d", diff, bout);

    // Random sweep against the arithmetic model.
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      model(ra, rb, rbin, md, mbo, mov);
      run_op(ra, rb, rbin, 1'b1, lat);
      $display("rnd %0d: a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d ovf=%0d", n, ra, rb, rbin, diff, bout, ovf_v);
      check("rnd_diff", 32'(diff), 32'(md));
      check("rnd_bout", 32'(bout), 32'(mbo));
`ifdef SERIAL_SUB_OVF_EN
      check("rnd_ovf", 32'(ovf_v), 32'(mov));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
